// File: rtl/sound_scheduler.sv
// Fixed-priority sequencer of four ROM sound clips into the audio FIFO.
// Define SOUND_SCHED_LOOP_EN to honour the loop input; otherwise every clip plays once.
module sound_scheduler #(
    parameter int DIV    = 1200,
    parameter int ADDR_W = 18
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [5:0]        rom_q,
    input  logic              audio_out_allowed,
    output logic              write_audio_out,
    output logic [31:0]       left_channel_audio_out,
    output logic              busy,
    output logic [1:0]        active_clip,
    output logic              done,
    output logic              overrun
);
    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    localparam logic [ADDR_W-1:0] WIN_S = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] WIN_E = ADDR_W'(16395);
    localparam logic [ADDR_W-1:0] MOO_S = ADDR_W'(16396);
    localparam logic [ADDR_W-1:0] MOO_E = ADDR_W'(66982);
    localparam logic [ADDR_W-1:0] DET_S = ADDR_W'(66983);
    localparam logic [ADDR_W-1:0] DET_E = ADDR_W'(83254);
    localparam logic [ADDR_W-1:0] CHR_S = ADDR_W'(83255);
    localparam logic [ADDR_W-1:0] CHR_E = ADDR_W'(137138);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [1:0]        clip_n;
    logic [DW-1:0]     div, div_n;
    logic [3:0]        pend, pend_n, pend_eff, clr;
    logic [5:0]        sample_reg, sample_n;
    logic              sample_valid, sv_n;
    logic              done_n, ovr_n;
    logic [1:0]        pick;
    logic              tick, load, loop_act;

    function automatic logic [ADDR_W-1:0] clip_start(input logic [1:0] c);
        logic [ADDR_W-1:0] r;
        unique case (c)
            2'd0: r = WIN_S;
            2'd1: r = MOO_S;
            2'd2: r = DET_S;
            2'd3: r = CHR_S;
        endcase
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] clip_end(input logic [1:0] c);
        logic [ADDR_W-1:0] r;
        unique case (c)
            2'd0: r = WIN_E;
            2'd1: r = MOO_E;
            2'd2: r = DET_E;
            2'd3: r = CHR_E;
        endcase
        return r;
    endfunction

    assign busy                   = (state == PLAY);
    assign write_audio_out        = sample_valid & audio_out_allowed;
    assign left_channel_audio_out = {sample_reg, 26'b0};

    always_comb begin
        // Requests in flight count as pending so an idle scheduler starts next cycle
        pend_eff = stop ? 4'b0 : (pend | req);
        priority case (1'b1)
            pend_eff[0]: pick = 2'd0;
            pend_eff[1]: pick = 2'd1;
            pend_eff[2]: pick = 2'd2;
            pend_eff[3]: pick = 2'd3;
            default:     pick = 2'd0;
        endcase
        tick     = (state == PLAY) && (div == DIV_MAX);
        load     = 1'b0;
        state_n  = state;
        addr_n   = rom_addr;
        clip_n   = active_clip;
        div_n    = '0;
        done_n   = 1'b0;
        clr      = 4'b0;
        unique case (state)
            IDLE: begin
                addr_n = '0;
                if (|pend_eff) load = 1'b1;
            end
            PLAY: begin
                div_n = tick ? '0 : div + 1'b1;
                if (tick) begin
                    if ((|pend_eff) && (pick < active_clip)) begin
                        load = 1'b1;
                    end else if (rom_addr != clip_end(active_clip)) begin
                        addr_n = rom_addr + 1'b1;
                    end else if (loop_act) begin
                        addr_n = clip_start(active_clip);
                    end else if (|pend_eff) begin
                        load   = 1'b1;
                        done_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        addr_n  = '0;
                        done_n  = 1'b1;
                    end
                end
            end
        endcase
        if (load) begin
            state_n = PLAY;
            addr_n  = clip_start(pick);
            clip_n  = pick;
            div_n   = '0;
            clr     = 4'b0001 << pick;
        end
        pend_n   = pend_eff & ~clr;
        sample_n = tick ? rom_q : sample_reg;
        if (tick) sv_n = 1'b1;
        else if (write_audio_out) sv_n = 1'b0;
        else sv_n = sample_valid;
        ovr_n = overrun | (tick & sample_valid & ~audio_out_allowed);
        if (stop) begin
            state_n = IDLE;
            addr_n  = '0;
            div_n   = '0;
            done_n  = 1'b0;
            sv_n    = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= IDLE;
            rom_addr     <= '0;
            active_clip  <= 2'd0;
            div          <= '0;
            pend         <= 4'b0;
            sample_reg   <= 6'd0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_n;
            rom_addr     <= addr_n;
            active_clip  <= clip_n;
            div          <= div_n;
            pend         <= pend_n;
            sample_reg   <= sample_n;
            sample_valid <= sv_n;
            done         <= done_n;
            overrun      <= ovr_n;
        end
    end

`ifdef SOUND_SCHED_LOOP_EN
    logic loop_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) loop_q <= 1'b0;
        else if (load) loop_q <= loop;
    end

    assign loop_act = loop_q;
`else
    logic unused_loop;

    assign unused_loop = loop;
    assign loop_act    = 1'b0;
`endif
endmodule

// File: tb/tb_sound_scheduler.sv
// Scoreboard bench for sound_scheduler: preemption, clip hand-off, overrun, reset, stop.
module tb_sound_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic        stop;
    logic        loop;
    logic [17:0] rom_addr;
    logic [5:0]  rom_q;
    logic        allowed;
    logic        write_audio_out;
    logic [31:0] left;
    logic        busy;
    logic [1:0]  active_clip;
    logic        done;
    logic        overrun;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int n_writes = 0;
    logic [31:0] exp_q[$];

    sound_scheduler #(.DIV(4), .ADDR_W(18)) dut (
        .CLOCK_50              (clk),
        .reset                 (reset),
        .req                   (req),
        .stop                  (stop),
        .loop                  (loop),
        .rom_addr              (rom_addr),
        .rom_q                 (rom_q),
        .audio_out_allowed     (allowed),
        .write_audio_out       (write_audio_out),
        .left_channel_audio_out(left),
        .busy                  (busy),
        .active_clip           (active_clip),
        .done                  (done),
        .overrun               (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] rom_f(input logic [17:0] a);
        return a[5:0] ^ a[11:6] ^ a[17:12];
    endfunction

    function automatic logic [31:0] word(input int a);
        return {rom_f(18'(a)), 26'b0};
    endfunction

    // One-cycle-latency ROM model
    always @(posedge clk) rom_q <= rom_f(rom_addr);

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (write_audio_out) begin
            logic [31:0] e;
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sample: unexpected write %h", left);
            end else begin
                e = exp_q.pop_front();
                if (left !== e) begin
                    errors++;
                    $display("FAIL sample: got %h expected %h", left, e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_wr"}, 32'(write_audio_out), 32'd0);
        chk({tag, "_left"}, left, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_clip"}, 32'(active_clip), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        req     = 4'b0;
        stop    = 1'b0;
        loop    = 1'b0;
        allowed = 1'b1;
        step(3);
        chk_zero("rst");
        reset = 1'b0;
        step(2);
        chk("idle_busy", 32'(busy), 32'd0);

        // detect starts, then win+cheer arrive and win preempts at the tick
        req = 4'b0100;
        exp_q.push_back(word(66983));
        step(1);
        req = 4'b0;
        chk("det_busy", 32'(busy), 32'd1);
        chk("det_addr", 32'(rom_addr), 32'd66983);
        chk("det_clip", 32'(active_clip), 32'd2);
        step(2);
`ifndef SOUND_SCHED_LOOP_EN
        loop = 1'b1;
`endif
        req = 4'b1001;
        step(1);
        req = 4'b0;
        chk("det_hold", 32'(rom_addr), 32'd66983);
        step(1);
        loop = 1'b0;
        chk("pre_addr", 32'(rom_addr), 32'd0);
        chk("pre_clip", 32'(active_clip), 32'd0);
        chk("pre_busy", 32'(busy), 32'd1);
        chk("pre_done", 32'(done), 32'd0);
        chk("pre_wr", 32'(write_audio_out), 32'd1);
        for (int a = 0; a <= 16395; a++) exp_q.push_back(word(a));
        step(3);
        chk("first_lat_wr", 32'(write_audio_out), 32'd0);
        step(1);
        chk("first_wr", 32'(write_audio_out), 32'd1);
        chk("step_addr", 32'(rom_addr), 32'd1);

        // win runs to its end, cheer follows on the same tick
        step(65579);
        chk("win_last", 32'(rom_addr), 32'd16395);
        chk("win_nodone", 32'(done), 32'd0);
        chk("drop_nodone", 32'(done_cnt), 32'd0);
        step(1);
        chk("end_done", 32'(done), 32'd1);
        chk("chr_addr", 32'(rom_addr), 32'd83255);
        chk("chr_clip", 32'(active_clip), 32'd3);
        chk("chr_busy", 32'(busy), 32'd1);
        exp_q.push_back(word(83256));
        exp_q.push_back(word(83257));
        step(1);
        chk("done_pulse", 32'(done), 32'd0);
        chk("done_cnt1", 32'(done_cnt), 32'd1);

        // FIFO full across two ticks
        allowed = 1'b0;
        step(3);
        chk("ovr_pre", 32'(overrun), 32'd0);
        chk("wr_blocked", 32'(write_audio_out), 32'd0);
        step(4);
        chk("ovr_set", 32'(overrun), 32'd1);
        step(1);
        allowed = 1'b1;
        step(3);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // reset mid-cheer with a moo request pending
        req = 4'b0010;
        step(1);
        req   = 4'b0;
        reset = 1'b1;
        step(1);
        chk_zero("midrst");
        reset = 1'b0;
        step(8);
        chk("pend_lost_busy", 32'(busy), 32'd0);
        chk("pend_lost_addr", 32'(rom_addr), 32'd0);

        // moo starts from idle, then stop beats a same-cycle request
        req = 4'b0010;
        exp_q.push_back(word(16396));
        step(1);
        req = 4'b0;
        chk("moo_busy", 32'(busy), 32'd1);
        chk("moo_addr", 32'(rom_addr), 32'd16396);
        chk("moo_clip", 32'(active_clip), 32'd1);
        step(4);
        chk("moo_step", 32'(rom_addr), 32'd16397);
        chk("moo_wr", 32'(write_audio_out), 32'd1);
        step(1);
        stop = 1'b1;
        req  = 4'b0001;
        step(1);
        stop = 1'b0;
        req  = 4'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_addr", 32'(rom_addr), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        step(6);
        chk("stop_idle", 32'(busy), 32'd0);
        chk("stop_wr", 32'(write_audio_out), 32'd0);
        chk("done_cnt_end", 32'(done_cnt), 32'd1);

        step(2);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("write_count", 32'(n_writes), 32'd16400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
